// File: rtl/cubehash_seq_pkg.sv
// rtl/cubehash_seq_pkg.sv - shared types and constants for the CubeHash sequencer
// Contents: sequencer state enum, err_code values, default geometry constants.
package cubehash_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_LOAD,
    S_FETCH,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;

  localparam int DEF_IOSIZE       = 16;
  localparam int DEF_BLOCK_WORDS  = 16;
  localparam int DEF_DIGEST_WORDS = 32;
  localparam int DEF_TIMEOUT      = 1024;

endpackage

// File: rtl/cubehash_seq_wdog.sv
// rtl/cubehash_seq_wdog.sv - handshake watchdog for core load/fetch strobes
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   strobe    : a core strobe (load or fetch) is asserted this cycle
//   ack       : core acknowledge
//   clr       : force the count back to zero
//   expired   : this cycle is the TIMEOUT-th consecutive unacknowledged strobe
module cubehash_seq_wdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  input  logic ack,
  input  logic clr,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] cnt;
  logic          waiting;

  assign waiting = strobe & ~ack;

  // Flagged combinationally on the TIMEOUT-th waiting cycle so the FSM
  // leaves on that same edge instead of holding the strobe one cycle longer.
  assign expired = waiting & (cnt == CW'(TIMEOUT - 1));

  // A dropped strobe (host stall, digest backpressure) restarts the count.
  always_ff @(posedge clk) begin
    if (rst || clr || !waiting) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/cubehash_seq.sv
// rtl/cubehash_seq.sv - sequencer driving one CubeHash core through init, load and fetch
// Ports:
//   clk, rst                                 : clock, synchronous active-high reset
//   start                                    : begin a hash (honoured in IDLE or ERR)
//   msg_valid/msg_data/msg_last/msg_ready    : host message word stream
//   dig_valid/dig_data/dig_last/dig_ready    : digest word stream to host
//   busy, done, err, err_code                : status
//   core_init/core_load/core_fetch/core_idata: strobes and data to the core
//   core_ack/core_odata                      : handshake and data from the core
module cubehash_seq
  import cubehash_seq_pkg::*;
#(
  parameter int IOSIZE       = DEF_IOSIZE,
  parameter int BLOCK_WORDS  = DEF_BLOCK_WORDS,
  parameter int DIGEST_WORDS = DEF_DIGEST_WORDS,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              msg_valid,
  input  logic [IOSIZE-1:0] msg_data,
  input  logic              msg_last,
  output logic              msg_ready,
  output logic              dig_valid,
  output logic [IOSIZE-1:0] dig_data,
  output logic              dig_last,
  input  logic              dig_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              core_init,
  output logic              core_load,
  output logic              core_fetch,
  output logic [IOSIZE-1:0] core_idata,
  input  logic              core_ack,
  input  logic [IOSIZE-1:0] core_odata
);

  localparam int WCW = $clog2(BLOCK_WORDS);
  localparam int DCW = $clog2(DIGEST_WORDS);

  state_t           state;
  state_t           state_nx;
  logic [WCW-1:0]   wcnt;
  logic [DCW-1:0]   dcnt;
  logic [1:0]       err_code_r;
  logic [1:0]       code_nx;
  logic             wd_expired;
  logic             load_xfer;
  logic             fetch_xfer;

  cubehash_seq_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .strobe  (core_load | core_fetch),
    .ack     (core_ack),
    .clr     (state == S_INIT),
    .expired (wd_expired)
  );

  // Strobes and stream handshakes are combinational pass-throughs gated by
  // state, so the host and core see each other directly with no added latency.
  always_comb begin
    state_nx   = state;
    code_nx    = ERR_NONE;
    msg_ready  = 1'b0;
    dig_valid  = 1'b0;
    dig_data   = '0;
    dig_last   = 1'b0;
    core_init  = 1'b0;
    core_load  = 1'b0;
    core_fetch = 1'b0;
    core_idata = '0;
    load_xfer  = 1'b0;
    fetch_xfer = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) state_nx = S_INIT;
      end

      S_INIT: begin
        core_init = 1'b1;
        state_nx  = S_LOAD;
      end

      S_LOAD: begin
        core_load  = msg_valid;
        core_idata = msg_data;
        msg_ready  = msg_valid & core_ack;
        load_xfer  = msg_ready;
        // A timeout needs ack low and a transfer needs ack high, so these
        // two branches never compete.
        if (wd_expired) begin
          state_nx = S_ERR;
          code_nx  = ERR_TIMEOUT;
        end else if (load_xfer && msg_last) begin
          if (wcnt == WCW'(BLOCK_WORDS - 1)) begin
            state_nx = S_FETCH;
          end else begin
            state_nx = S_ERR;
            code_nx  = ERR_LEN;
          end
        end
      end

      S_FETCH: begin
        core_fetch = dig_ready;
        dig_valid  = dig_ready & core_ack;
        dig_data   = core_odata;
        fetch_xfer = dig_valid;
        dig_last   = dig_valid & (dcnt == DCW'(DIGEST_WORDS - 1));
        if (wd_expired) begin
          state_nx = S_ERR;
          code_nx  = ERR_TIMEOUT;
        end else if (dig_last) begin
          state_nx = S_DONE;
        end
      end

      S_DONE: begin
        state_nx = S_IDLE;
      end

      S_ERR: begin
        if (start) state_nx = S_INIT;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wcnt       <= '0;
      dcnt       <= '0;
      err_code_r <= ERR_NONE;
    end else begin
      state <= state_nx;

      if (state == S_INIT) begin
        wcnt <= '0;
        dcnt <= '0;
      end else begin
        if (load_xfer) begin
          wcnt <= (wcnt == WCW'(BLOCK_WORDS - 1)) ? '0 : wcnt + WCW'(1);
        end
        if (fetch_xfer) begin
          dcnt <= dcnt + DCW'(1);
        end
      end

      if (state_nx == S_ERR && state != S_ERR) begin
        err_code_r <= code_nx;
      end else if (state == S_ERR && start) begin
        err_code_r <= ERR_NONE;
      end
    end
  end

  assign busy     = (state != S_IDLE) && (state != S_ERR);
  assign done     = (state == S_DONE);
  assign err      = (state == S_ERR);
  assign err_code = err_code_r;

endmodule
